// File: rtl/axis_stream_fifo.sv
// DEPTH-entry first-word-fall-through AXI-stream queue with a TLAST sideband,
// fill level, almost-full flag, stored-packet count and synchronous flush.
module axis_stream_fifo #(
   parameter  int N            = 4,
   parameter  int DATA_WIDTH   = 8,
   parameter  int DEPTH        = 4,
   parameter  int AFULL_THRESH = DEPTH - 1,
   localparam int W            = N * DATA_WIDTH,
   localparam int LW           = $clog2(DEPTH + 1),
   localparam int PW           = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [W-1:0]  s_tdata,
   input  logic          s_tvalid,
   input  logic          s_tlast,
   output logic          s_tready,
   output logic [W-1:0]  m_tdata,
   output logic          m_tvalid,
   output logic          m_tlast,
   input  logic          m_tready,
   input  logic          flush,
   output logic [LW-1:0] level,
   output logic          almost_full,
   output logic [LW-1:0] pkt_count
);

   logic [W:0]    mem [DEPTH];
   logic [PW-1:0] wp;
   logic [PW-1:0] rp;
   logic [W:0]    head;
   logic          push;
   logic          pop;
   logic          pkt_inc;
   logic          pkt_dec;

   assign head        = mem[rp];
   assign s_tready    = ~reset & ~flush & (level != LW'(DEPTH));
   assign m_tvalid    = (level != '0);
   assign push        = s_tvalid & s_tready;
   assign pop         = m_tvalid & m_tready;
   // Stale storage never leaks out: the head is masked to zero while empty.
   assign m_tdata     = m_tvalid ? head[W-1:0] : '0;
   assign m_tlast     = m_tvalid & head[W];
   assign almost_full = (level >= LW'(AFULL_THRESH));
   assign pkt_inc     = push & s_tlast;
   assign pkt_dec     = pop & head[W];

   // NOTE: storage is deliberately not reset; only pointers and counters are.
   always_ff @(posedge clk) begin
      if (push) mem[wp] <= {s_tlast, s_tdata};
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wp        <= '0;
         rp        <= '0;
         level     <= '0;
         pkt_count <= '0;
      end else begin
         if (push) wp <= wp + PW'(1);
         if (pop)  rp <= rp + PW'(1);
         case ({push, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
         case ({pkt_inc, pkt_dec})
            2'b10:   pkt_count <= pkt_count + LW'(1);
            2'b01:   pkt_count <= pkt_count - LW'(1);
            default: pkt_count <= pkt_count;
         endcase
      end
   end

   a_level_bound : assert property (@(posedge clk) disable iff (reset) level <= LW'(DEPTH));
   a_pkt_bound   : assert property (@(posedge clk) disable iff (reset) pkt_count <= level);

endmodule

// File: tb/tb_axis_stream_fifo.sv
// Self-checking bench for axis_stream_fifo: directed scenarios plus a random
// stall run, all scored against a queue-based reference model.
module tb_axis_stream_fifo;

   localparam int DEPTH = 4;
   localparam int W     = 32;

   typedef struct {
      logic [W-1:0] d;
      logic         l;
   } beat_t;

   logic         clk = 1'b0;
   logic         reset;
   logic [W-1:0] s_tdata;
   logic         s_tvalid;
   logic         s_tlast;
   logic         s_tready;
   logic [W-1:0] m_tdata;
   logic         m_tvalid;
   logic         m_tlast;
   logic         m_tready;
   logic         flush;
   logic [2:0]   level;
   logic         almost_full;
   logic [2:0]   pkt_count;

   int    n_cmp = 0;
   int    n_err = 0;
   beat_t q[$];
   logic  rdy_seen;
   logic  pushed;
   logic  popped;

   axis_stream_fifo #(.N(4), .DATA_WIDTH(8), .DEPTH(DEPTH), .AFULL_THRESH(DEPTH - 1)) dut (
      .clk(clk), .reset(reset),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
      .flush(flush), .level(level), .almost_full(almost_full), .pkt_count(pkt_count)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int mdl_pkts();
      int c = 0;
      foreach (q[i]) if (q[i].l) c++;
      return c;
   endfunction

   // One clock cycle: apply inputs, sample s_tready, advance the model at the edge.
   task automatic step(input logic sv, input logic [W-1:0] sd, input logic sl,
                       input logic mr, input logic fl, input logic rs);
      logic  do_push;
      logic  do_pop;
      beat_t b;
      s_tvalid = sv; s_tdata = sd; s_tlast = sl; m_tready = mr; flush = fl; reset = rs;
      #1;
      rdy_seen = s_tready;
      do_push  = sv && !fl && !rs && (q.size() < DEPTH);
      do_pop   = mr && (q.size() > 0) && !fl && !rs;
      @(posedge clk);
      if (rs || fl) q.delete();
      else begin
         if (do_pop) q.delete(0);
         if (do_push) begin b.d = sd; b.l = sl; q.push_back(b); end
      end
      pushed = do_push;
      popped = do_pop;
      #1;
   endtask

   task automatic test_reset();
      step(0, '0, 0, 0, 0, 1);
      n_cmp++; if (rdy_seen !== 1'b0) begin n_err++; $display("FAIL reset_tready_low: got %b want 0", rdy_seen); end
      step(0, '0, 0, 0, 0, 1);
      s_tvalid = 0; m_tready = 0; flush = 0; reset = 0; #1;
      n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL reset_level: got %0d want 0", level); end
      n_cmp++; if (pkt_count !== 3'd0) begin n_err++; $display("FAIL reset_pkt: got %0d want 0", pkt_count); end
      n_cmp++; if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_mvalid: got %b want 0", m_tvalid); end
      n_cmp++; if (m_tdata !== '0) begin n_err++; $display("FAIL reset_mdata: got %h want 0", m_tdata); end
      n_cmp++; if (m_tlast !== 1'b0) begin n_err++; $display("FAIL reset_mlast: got %b want 0", m_tlast); end
      n_cmp++; if (almost_full !== 1'b0) begin n_err++; $display("FAIL reset_afull: got %b want 0", almost_full); end
      n_cmp++; if (s_tready !== 1'b1) begin n_err++; $display("FAIL reset_tready: got %b want 1", s_tready); end
   endtask

   task automatic test_fill_drain();
      logic [W-1:0] fd [4] = '{32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10};
      for (int i = 0; i < 4; i++) begin
         step(1, fd[i], 0, 0, 0, 0);
         n_cmp++; if (level !== 3'(i + 1)) begin n_err++; $display("FAIL fill_level: got %0d want %0d", level, i + 1); end
         n_cmp++; if (almost_full !== ((i + 1) >= 3)) begin n_err++; $display("FAIL fill_afull: level %0d got %b", i + 1, almost_full); end
      end
      n_cmp++; if (s_tready !== 1'b0) begin n_err++; $display("FAIL full_tready: got %b want 0", s_tready); end
      step(1, 32'hAAAAAAAA, 0, 0, 0, 0);
      n_cmp++; if (level !== 3'd4) begin n_err++; $display("FAIL fifth_beat_level: got %0d want 4", level); end
      for (int i = 0; i < 4; i++) begin
         n_cmp++; if (m_tvalid !== 1'b1 || m_tdata !== fd[i]) begin
            n_err++; $display("FAIL drain_beat%0d: got v=%b d=%h want v=1 d=%h", i, m_tvalid, m_tdata, fd[i]);
         end
         step(0, '0, 0, 1, 0, 0);
         if (i == 0) begin
            n_cmp++; if (s_tready !== 1'b1) begin n_err++; $display("FAIL post_pop_tready: got %b want 1", s_tready); end
         end
      end
      n_cmp++; if (m_tvalid !== 1'b0 || m_tdata !== '0) begin
         n_err++; $display("FAIL drained_empty: got v=%b d=%h want v=0 d=0", m_tvalid, m_tdata);
      end
   endtask

   task automatic test_streaming();
      logic [W-1:0] base = 32'h1000_0000;
      for (int i = 0; i < 20; i++) begin
         if (i == 0) begin
            n_cmp++; if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL stream_start_valid: got %b want 0", m_tvalid); end
         end else begin
            n_cmp++; if (m_tvalid !== 1'b1 || m_tdata !== base + W'(i - 1) || level !== 3'd1) begin
               n_err++; $display("FAIL stream_beat%0d: got v=%b d=%h lvl=%0d want v=1 d=%h lvl=1",
                                 i - 1, m_tvalid, m_tdata, level, base + W'(i - 1));
            end
         end
         step(1, base + W'(i), 0, 1, 0, 0);
      end
      n_cmp++; if (m_tvalid !== 1'b1 || m_tdata !== base + W'(19)) begin
         n_err++; $display("FAIL stream_last: got v=%b d=%h want v=1 d=%h", m_tvalid, m_tdata, base + W'(19));
      end
      step(0, '0, 0, 1, 0, 0);
      n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL stream_end_level: got %0d want 0", level); end
   endtask

   task automatic test_tlast();
      logic tl [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 4; i++) step(1, W'($urandom), tl[i], 0, 0, 0);
      n_cmp++; if (pkt_count !== 3'd2) begin n_err++; $display("FAIL tlast_pkt_full: got %0d want 2", pkt_count); end
      step(0, '0, 0, 1, 0, 0);
      step(0, '0, 0, 1, 0, 0);
      n_cmp++; if (pkt_count !== 3'd1 || m_tlast !== 1'b0) begin
         n_err++; $display("FAIL tlast_after_two_pops: got pkt=%0d last=%b want pkt=1 last=0", pkt_count, m_tlast);
      end
      step(0, '0, 0, 1, 0, 0);
      n_cmp++; if (m_tlast !== 1'b1) begin n_err++; $display("FAIL tlast_head: got %b want 1", m_tlast); end
      step(1, W'($urandom), 1, 1, 0, 0);
      n_cmp++; if (pkt_count !== 3'd1 || level !== 3'd1) begin
         n_err++; $display("FAIL tlast_simul: got pkt=%0d lvl=%0d want pkt=1 lvl=1", pkt_count, level);
      end
      step(0, '0, 0, 1, 0, 0);
      n_cmp++; if (pkt_count !== 3'd0) begin n_err++; $display("FAIL tlast_drained: got %0d want 0", pkt_count); end
   endtask

   task automatic test_flush();
      for (int i = 0; i < 3; i++) step(1, W'($urandom), 1, 0, 0, 0);
      step(1, 32'hDEADBEEF, 1, 0, 1, 0);
      n_cmp++; if (rdy_seen !== 1'b0) begin n_err++; $display("FAIL flush_tready: got %b want 0", rdy_seen); end
      n_cmp++; if (level !== 3'd0 || pkt_count !== 3'd0 || m_tvalid !== 1'b0) begin
         n_err++; $display("FAIL flush_clear: got lvl=%0d pkt=%0d v=%b want 0/0/0", level, pkt_count, m_tvalid);
      end
      step(0, '0, 0, 0, 0, 0);
      n_cmp++; if (level !== 3'd0 || m_tvalid !== 1'b0) begin
         n_err++; $display("FAIL flush_beat_dropped: got lvl=%0d v=%b want 0/0", level, m_tvalid);
      end
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] d;
      step(1, W'($urandom), 0, 0, 0, 0);
      step(1, W'($urandom), 1, 0, 0, 0);
      step(1, W'($urandom), 0, 0, 0, 1);
      n_cmp++; if (level !== 3'd0 || m_tvalid !== 1'b0 || m_tdata !== '0 || almost_full !== 1'b0) begin
         n_err++; $display("FAIL midreset: got lvl=%0d v=%b d=%h af=%b want all 0", level, m_tvalid, m_tdata, almost_full);
      end
      d = 32'h5A5A_1234;
      step(1, d, 1, 0, 0, 0);
      n_cmp++; if (m_tvalid !== 1'b1 || m_tdata !== d || m_tlast !== 1'b1 || pkt_count !== 3'd1) begin
         n_err++; $display("FAIL midreset_resume: got v=%b d=%h l=%b pkt=%0d want v=1 d=%h l=1 pkt=1",
                           m_tvalid, m_tdata, m_tlast, pkt_count, d);
      end
      step(0, '0, 0, 1, 0, 0);
   endtask

   task automatic test_random();
      int           sent  = 0;
      int           recvd = 0;
      int           cyc   = 0;
      logic         sv;
      logic [W-1:0] sd   = W'($urandom);
      logic         sl   = 1'($urandom);
      logic [W-1:0] exp_d;
      while ((sent < 100 || q.size() > 0) && cyc < 3000) begin
         exp_d = (q.size() > 0) ? q[0].d : '0;
         n_cmp++;
         if (m_tvalid !== (q.size() > 0) || m_tdata !== exp_d ||
             m_tlast !== ((q.size() > 0) && q[0].l) || level !== 3'(q.size()) ||
             pkt_count !== 3'(mdl_pkts()) || almost_full !== (q.size() >= DEPTH - 1) ||
             s_tready !== (q.size() < DEPTH)) begin
            n_err++;
            $display("FAIL random_cycle%0d: got v=%b d=%h l=%b lvl=%0d pkt=%0d af=%b rdy=%b want lvl=%0d d=%h pkt=%0d",
                     cyc, m_tvalid, m_tdata, m_tlast, level, pkt_count, almost_full, s_tready,
                     q.size(), exp_d, mdl_pkts());
         end
         sv = (sent < 100) && ($urandom_range(1, 0) == 1);
         step(sv, sd, sl, ($urandom_range(1, 0) == 1), 0, 0);
         if (pushed) begin sent++; sd = W'($urandom); sl = 1'($urandom); end
         if (popped) recvd++;
         cyc++;
      end
      n_cmp++; if (recvd !== 100 || sent !== 100) begin
         n_err++; $display("FAIL random_totals: got sent=%0d recvd=%0d cycles=%0d want 100/100", sent, recvd, cyc);
      end
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_streaming();
      test_tlast();
      test_flush();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
